terminal_writer: RTL and testbench

Write-side controller for the 40×64 character terminal buffer that the character sprite renderer reads. It accepts one ASCII code per valid/ready handshake and keeps a text cursor. It turns each code into write transactions on the buffer's write port: character writes, backspace erase, newline/row clear, and a full clear after reset. It sits between the keyboard/UART decoder and the character buffer RAM. It also drives the cursor position and the top-row offset that the renderer uses.

---
 rtl/terminal_pkg.sv | 24 ++
 rtl/terminal_cursor.sv | 80 ++++++++
 rtl/terminal_writer.sv | 144 ++++++++++++++
 tb/tb_terminal_writer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/terminal_pkg.sv
// Shared constants, state encoding and default geometry for the terminal buffer writer.
package terminal_pkg;

  localparam int unsigned DEF_COLS = 64;
  localparam int unsigned DEF_ROWS = 40;

  localparam logic [7:0] CHAR_SPACE     = 8'h20;
  localparam logic [7:0] CHAR_BS        = 8'h08;
  localparam logic [7:0] CHAR_LF        = 8'h0A;
  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
  localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    INIT_CLEAR,
    IDLE,
    CLEAR_ROW
  } term_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_PRINT_MIN) && (c <= CHAR_PRINT_MAX);
  endfunction

endpackage

// File: rtl/terminal_cursor.sv
// Text cursor: col/row registers plus the per-character cursor arithmetic and write request.
module terminal_cursor
  import terminal_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      accept,
  input  logic [7:0]                char_code,
  output logic [$clog2(COLS)-1:0]   col,
  output logic [$clog2(ROWS)-1:0]   row,
  output logic                      row_adv_c,
  output logic                      wr_req_c,
  output logic [$clog2(COLS)-1:0]   wr_col_c,
  output logic [7:0]                wr_char_c
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic             adv;

  // Decode the accepted code into a cursor move and an optional cell write.
  always_comb begin
    col_nxt   = col;
    row_nxt   = row;
    adv       = 1'b0;
    wr_req_c  = 1'b0;
    wr_col_c  = col;
    wr_char_c = char_code;
    if (accept) begin
      if (is_printable(char_code)) begin
        wr_req_c = 1'b1;
        if (col == COL_W'(COLS - 1)) begin
          col_nxt = '0;
          adv     = 1'b1;
        end else begin
          col_nxt = col + COL_W'(1);
        end
      end else begin
        case (char_code)
          CHAR_BS: begin
            if (col != '0) begin
              col_nxt   = col - COL_W'(1);
              wr_req_c  = 1'b1;
              wr_col_c  = col - COL_W'(1);
              wr_char_c = CHAR_SPACE;
            end
          end
          CHAR_LF: begin
            col_nxt = '0;
            adv     = 1'b1;
          end
          CHAR_CR: col_nxt = '0;
          default: ;
        endcase
      end
      if (adv) begin
        row_nxt = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
      end
    end
  end

  assign row_adv_c = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

endmodule

// File: rtl/terminal_writer.sv
// Write-side controller for the character terminal buffer: init clear, char writes, row clears.
// Optional circular scrolling of the displayed top row is enabled by TERMINAL_SCROLL_EN.
module terminal_writer
  import terminal_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_in,
  input  logic                          char_valid_in,
  input  logic [7:0]                    char_in,
  output logic                          char_ready_out,
  output logic                          wr_en_out,
  output logic [$clog2(ROWS*COLS)-1:0]  wr_addr_out,
  output logic [7:0]                    wr_data_out,
  output logic [$clog2(COLS)-1:0]       cursor_col_out,
  output logic [$clog2(ROWS)-1:0]       cursor_row_out,
  output logic [$clog2(ROWS)-1:0]       top_row_out
);

  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned ADDR_W = $clog2(CELLS);
  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ROW_W  = $clog2(ROWS);

  term_state_t       state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic              accept;
  logic              row_adv_c;
  logic              wr_req_c;
  logic [COL_W-1:0]  wr_col_c;
  logic [7:0]        wr_char_c;
  logic [ADDR_W-1:0] row_base;

  assign char_ready_out = (state == IDLE);
  assign accept         = char_valid_in && char_ready_out;
  assign row_base       = ADDR_W'(cursor_row_out) * ADDR_W'(COLS);

  terminal_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk       (pixel_clk_in),
    .rst       (rst_in),
    .accept    (accept),
    .char_code (char_in),
    .col       (cursor_col_out),
    .row       (cursor_row_out),
    .row_adv_c (row_adv_c),
    .wr_req_c  (wr_req_c),
    .wr_col_c  (wr_col_c),
    .wr_char_c (wr_char_c)
  );

  // Next state, clear counter and the write to register this cycle.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_out;
    wr_data_nxt = wr_data_out;
    case (state)
      INIT_CLEAR: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = clr_cnt;
        wr_data_nxt = CHAR_SPACE;
        if (clr_cnt == ADDR_W'(CELLS - 1)) begin
          clr_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (wr_req_c) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = row_base + ADDR_W'(wr_col_c);
          wr_data_nxt = wr_char_c;
        end
        if (row_adv_c) begin
          clr_cnt_nxt = '0;
          state_nxt   = CLEAR_ROW;
        end
      end
      CLEAR_ROW: begin
        // Cursor row already points at the newly entered row here.
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = row_base + clr_cnt;
        wr_data_nxt = CHAR_SPACE;
        if (clr_cnt == ADDR_W'(COLS - 1)) begin
          clr_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = INIT_CLEAR;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= INIT_CLEAR;
      clr_cnt     <= '0;
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      wr_en_out   <= wr_en_nxt;
      wr_addr_out <= wr_addr_nxt;
      wr_data_out <= wr_data_nxt;
    end
  end

`ifdef TERMINAL_SCROLL_EN
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == ROW_W'(ROWS - 1)) ? '0 : r + ROW_W'(1);
  endfunction

  logic wrapped;

  // Once the cursor has wrapped, the screen top follows one row below the cursor.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      wrapped     <= 1'b0;
      top_row_out <= '0;
    end else if (row_adv_c) begin
      if (wrapped || (cursor_row_out == ROW_W'(ROWS - 1))) begin
        wrapped     <= 1'b1;
        top_row_out <= row_inc(row_inc(cursor_row_out));
      end
    end
  end
`else
  assign top_row_out = '0;
`endif

endmodule

// File: tb/tb_terminal_writer.sv
// Directed self-checking bench for terminal_writer with hand-computed expectations.
module tb_terminal_writer;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  ch;
  logic        ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  col;
  logic [5:0]  row;
  logic [5:0]  top;

  int n_chk  = 0;
  int n_pass = 0;

  terminal_writer dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .char_valid_in  (valid),
    .char_in        (ch),
    .char_ready_out (ready),
    .wr_en_out      (wr_en),
    .wr_addr_out    (wr_addr),
    .wr_data_out    (wr_data),
    .cursor_col_out (col),
    .cursor_row_out (row),
    .top_row_out    (top)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one code for exactly one edge; outputs reflecting that edge are valid on return.
  task automatic send(input logic [7:0] c);
    chk("ready_before_send", 32'(ready), 32'd1);
    valid = 1'b1;
    ch    = c;
    step();
    valid = 1'b0;
  endtask

  // Full-buffer clear after reset release, in order, ready low until the last write lands.
  task automatic init_check(input string tag);
    int n, bad, cyc;
    n = 0; bad = 0; cyc = 0;
    while (!ready && cyc < 3000) begin
      step();
      cyc++;
      if (wr_en) begin
        if (wr_addr != 12'(n) || wr_data != 8'h20) bad++;
        n++;
      end
    end
    chk({tag, "_write_count"}, 32'(n), 32'd2560);
    chk({tag, "_order_bad"},   32'(bad), 32'd0);
    chk({tag, "_edges"},       32'(cyc), 32'd2560);
    chk({tag, "_ready"},       32'(ready), 32'd1);
  endtask

  // Wait for a row clear to finish, checking addresses base..base+63 and ready-low length.
  task automatic clear_check(input string tag, input int base, output int bad, output int low);
    int k, guard;
    k = 0; bad = 0; low = 0; guard = 0;
    while (!ready && guard < 200) begin
      low++;
      guard++;
      step();
      if (wr_en) begin
        if (wr_addr != 12'(base + k) || wr_data != 8'h20) bad++;
        k++;
      end
    end
    if (k != 64) bad++;
    if (!ready) chk({tag, "_timeout"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int bad, low, top_exp;
`ifdef TERMINAL_SCROLL_EN
    top_exp = 1;
`else
    top_exp = 0;
`endif
    rst = 1'b1; valid = 1'b0; ch = 8'h00;
    #1;
    chk("rst_wr_en",  32'(wr_en),   32'd0);
    chk("rst_ready",  32'(ready),   32'd0);
    chk("rst_addr",   32'(wr_addr), 32'd0);
    chk("rst_col",    32'(col),     32'd0);
    chk("rst_row",    32'(row),     32'd0);
    chk("rst_top",    32'(top),     32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    init_check("init");

    // Single printable char
    send(8'h41);
    chk("a_wr_en", 32'(wr_en),   32'd1);
    chk("a_addr",  32'(wr_addr), 32'd0);
    chk("a_data",  32'(wr_data), 32'h41);
    chk("a_col",   32'(col),     32'd1);
    chk("a_row",   32'(row),     32'd0);

    // Ignored control code, then CR
    send(8'h07);
    chk("bel_no_write", 32'(wr_en), 32'd0);
    chk("bel_col",      32'(col),   32'd1);
    send(8'h0D);
    chk("cr_no_write",  32'(wr_en), 32'd0);
    chk("cr_col",       32'(col),   32'd0);

    // Full row back-to-back, then the row-1 clear
    bad = 0;
    valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ch = 8'(8'h21 + i);
      step();
      if (!wr_en || wr_addr != 12'(i) || wr_data != 8'(8'h21 + i)) bad++;
      if (i < 63 && !ready) bad++;
    end
    valid = 1'b0;
    chk("row_writes_bad", 32'(bad),   32'd0);
    chk("row_ready_drop", 32'(ready), 32'd0);
    clear_check("row_clr", 64, bad, low);
    chk("row_clr_bad",  32'(bad), 32'd0);
    chk("row_clr_low",  32'(low), 32'd64);
    chk("row_cur_row",  32'(row), 32'd1);
    chk("row_cur_col",  32'(col), 32'd0);

    // LF then reset in the middle of the row-2 clear
    send(8'h0A);
    chk("lf_no_write", 32'(wr_en), 32'd0);
    chk("lf_row",      32'(row),   32'd2);
    for (int i = 0; i < 10; i++) step();
    chk("mid_clr_en",   32'(wr_en),   32'd1);
    chk("mid_clr_addr", 32'(wr_addr), 32'd137);
    #2 rst = 1'b1;
    #1;
    chk("async_wr_en", 32'(wr_en), 32'd0);
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_row",   32'(row),   32'd0);
    chk("async_col",   32'(col),   32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    init_check("reinit");

    // Backspace handling
    send(8'h41);
    send(8'h42);
    chk("b_addr", 32'(wr_addr), 32'd1);
    chk("b_col",  32'(col),     32'd2);
    send(8'h08);
    chk("bs1_en",   32'(wr_en),   32'd1);
    chk("bs1_addr", 32'(wr_addr), 32'd1);
    chk("bs1_data", 32'(wr_data), 32'h20);
    chk("bs1_col",  32'(col),     32'd1);
    send(8'h08);
    chk("bs2_en",   32'(wr_en),   32'd1);
    chk("bs2_addr", 32'(wr_addr), 32'd0);
    chk("bs2_col",  32'(col),     32'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h08);
      if (wr_en || col != 6'd0 || row != 6'd0) bad++;
    end
    chk("bs_col0_bad", 32'(bad), 32'd0);
    chk("bs_hold_addr", 32'(wr_addr), 32'd0);

    // 40 line feeds wrap the cursor back to row 0
    for (int i = 0; i < 40; i++) begin
      int b, l;
      send(8'h0A);
      clear_check("lf_clr", ((i + 1) % 40) * 64, b, l);
      bad += b;
      if (i == 38) begin
        chk("lf39_row", 32'(row), 32'd39);
        chk("lf39_top", 32'(top), 32'd0);
      end
    end
    chk("lf_clr_bad",  32'(bad),     32'd0);
    chk("wrap_row",    32'(row),     32'd0);
    chk("wrap_col",    32'(col),     32'd0);
    chk("wrap_last",   32'(wr_addr), 32'd63);
    chk("wrap_top",    32'(top),     32'(top_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
